disp_value_feed: RTL and testbench

Upstream feeder for the 4-digit seven-segment display driver. Accepts a binary game value (score, ammo, timer) from core logic and converts it to four BCD digits with a sequential shift-add-3 engine. Blanks leading zeros and generates the free-running 2-bit digit-scan index. Its outputs connect directly to the display driver's `Scan`, `Hexs`, `point` and `LES` inputs.

---
 rtl/disp_value_feed_pkg.sv | 39 +++
 rtl/disp_value_feed_bcd_add3_step.sv | 19 +
 rtl/disp_value_feed.sv | 143 ++++++++++++++
 tb/tb_disp_value_feed.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_value_feed_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_value_feed_pkg: constants, FSM states and LES helper             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package disp_value_feed_pkg;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BIN_W      = 14;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  localparam logic [BIN_W-1:0] MAX_DISP   = 14'd9999;
  localparam logic [3:0]       CONV_ITERS = 4'd14;
  localparam logic [3:0]       LAST_ITER  = CONV_ITERS - 4'd1;

  // Shared with the display driver: a 1 on LES turns the digit off.
  localparam logic LES_BLANK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Digit 0 always lit; a higher digit blanks only if it and all above are 0.
  function automatic logic [BCD_DIGITS-1:0] les_from_bcd(input logic [BCD_W-1:0] bcd);
    logic [BCD_DIGITS-1:0] les;
    logic                  higher_zero;
    les         = {BCD_DIGITS{~LES_BLANK}};
    higher_zero = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      higher_zero = higher_zero & (bcd[4*i +: 4] == 4'd0);
      if (higher_zero) les[i] = LES_BLANK;
    end
    return les;
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_value_feed_bcd_add3_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_add3_step: adds 3 to every BCD nibble that is 5 or greater        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module bcd_add3_step
  import disp_value_feed_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [BCD_W-1:0] o_bcd
);

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_nibble
    assign o_bcd[4*g +: 4] = (i_bcd[4*g +: 4] >= 4'd5) ? (i_bcd[4*g +: 4] + 4'd3)
                                                       : i_bcd[4*g +: 4];
  end

endmodule
`default_nettype wire

// File: rtl/disp_value_feed.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_value_feed: binary-to-BCD feeder with blanking and scan index    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module disp_value_feed
  import disp_value_feed_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 17,
  parameter logic [3:0]  POINT_MASK = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  output logic [1:0]       Scan,
  output logic [BCD_W-1:0] Hexs,
  output logic [3:0]       point,
  output logic [3:0]       LES,
  output logic             busy,
  output logic             done
);

  localparam int unsigned          PRESC_W   = SCAN_DIV + 2;
  localparam logic [PRESC_W-1:0]   PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [PRESC_W-1:0] r_presc;
  state_t             r_state;
  state_t             w_next_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [3:0]         r_iter;
  logic               r_pend;
  logic [BIN_W-1:0]   r_pend_val;
  logic [BCD_W-1:0]   r_hexs;
  logic [3:0]         r_les;
  logic               r_done;

  logic [BIN_W-1:0]   w_clamped;
  logic [BCD_W-1:0]   w_add3;
  logic               w_start;
  logic [BIN_W-1:0]   w_start_val;
  logic               w_commit;
  logic               w_capture_pend;
  logic               w_clear_pend;

  assign w_clamped = (value > MAX_DISP) ? MAX_DISP : value;

  bcd_add3_step u_add3 (
    .i_bcd (r_bcd),
    .o_bcd (w_add3)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // A load arriving in COMMIT beats an older pending value: newest wins.
  always_comb begin
    w_next_state   = r_state;
    w_start        = 1'b0;
    w_start_val    = w_clamped;
    w_commit       = 1'b0;
    w_capture_pend = 1'b0;
    w_clear_pend   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_start      = 1'b1;
          w_next_state = ST_CONV;
        end
      end
      ST_CONV: begin
        w_capture_pend = load;
        if (r_iter == LAST_ITER) w_next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
        if (load) begin
          w_start      = 1'b1;
          w_clear_pend = 1'b1;
          w_next_state = ST_CONV;
        end else if (r_pend) begin
          w_start      = 1'b1;
          w_start_val  = r_pend_val;
          w_clear_pend = 1'b1;
          w_next_state = ST_CONV;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_hexs     <= '0;
      r_les      <= les_from_bcd('0);
      r_done     <= 1'b0;
    end else begin
      r_presc <= r_presc + PRESC_ONE;
      r_done  <= w_commit;

      if (w_start) begin
        r_bin  <= w_start_val;
        r_bcd  <= '0;
        r_iter <= '0;
      end else if (r_state == ST_CONV) begin
        {r_bcd, r_bin} <= {w_add3, r_bin} << 1;
        r_iter         <= r_iter + 4'd1;
      end

      if (w_commit) begin
        r_hexs <= r_bcd;
        r_les  <= les_from_bcd(r_bcd);
      end

      if (w_capture_pend) begin
        r_pend     <= 1'b1;
        r_pend_val <= w_clamped;
      end else if (w_clear_pend) begin
        r_pend     <= 1'b0;
      end
    end
  end

  assign Scan  = r_presc[PRESC_W-1 -: 2];
  assign Hexs  = r_hexs;
  assign LES   = r_les;
  assign point = POINT_MASK;
  assign busy  = (r_state != ST_IDLE);
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_disp_value_feed.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_disp_value_feed: scoreboard bench for disp_value_feed              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_disp_value_feed;

  localparam int unsigned SCAN_DIV   = 2;
  localparam logic [3:0]  POINT_MASK = 4'b0101;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value;
  logic        load;
  logic [1:0]  Scan;
  logic [15:0] Hexs;
  logic [3:0]  point;
  logic [3:0]  LES;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  logic [19:0] sb_q[$];

  always #5 clk = ~clk;

  disp_value_feed #(.SCAN_DIV(SCAN_DIV), .POINT_MASK(POINT_MASK)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .Scan  (Scan),
    .Hexs  (Hexs),
    .point (point),
    .LES   (LES),
    .busy  (busy),
    .done  (done)
  );

  function automatic logic [15:0] model_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000 % 10), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
  endfunction

  function automatic logic [3:0] model_les(input logic [15:0] h);
    if (h[15:12] != 4'd0) return 4'b0000;
    if (h[11:8]  != 4'd0) return 4'b1000;
    if (h[7:4]   != 4'd0) return 4'b1100;
    return 4'b1110;
  endfunction

  // Presents value with load for one clock; returns #1 after the sampling edge.
  task automatic drive_load(input int v);
    @(negedge clk);
    load  = 1'b1;
    value = 14'(v);
    @(posedge clk);
    #1;
    load  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; value = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (Hexs !== 16'h0000) begin fails++; $display("FAIL reset_hexs: got %h expected 0000", Hexs); end
    tests++; if (LES !== 4'b1110) begin fails++; $display("FAIL reset_les: got %b expected 1110", LES); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    tests++; if (point !== POINT_MASK) begin fails++; $display("FAIL reset_point: got %b expected %b", point, POINT_MASK); end
    tests++; if (Scan !== 2'd0) begin fails++; $display("FAIL reset_scan: got %0d expected 0", Scan); end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      tests++;
      if (Scan !== 2'((k / 4) % 4) || busy !== 1'b0) begin
        fails++;
        $display("FAIL scan_step k=%0d: got scan=%0d busy=%b expected scan=%0d busy=0", k, Scan, busy, (k / 4) % 4);
      end
    end
  endtask

  task automatic test_values;
    int vals[6] = '{1234, 7, 0, 90, 9999, 1};
    for (int n = 0; n < 6; n++) begin
      int cyc, bcnt;
      bit seen;
      logic [19:0] exp;
      cyc = 0; bcnt = 0; seen = 0;
      sb_q.push_back({model_bcd(vals[n]), model_les(model_bcd(vals[n]))});
      drive_load(vals[n]);
      while (!seen && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (busy === 1'b1) bcnt++;
        if (done === 1'b1) seen = 1;
      end
      exp = sb_q.pop_front();
      tests++;
      if (!seen || cyc != 16) begin fails++; $display("FAIL conv_latency v=%0d: got done at cycle %0d expected 16", vals[n], cyc); end
      tests++;
      if (bcnt != 15) begin fails++; $display("FAIL conv_busy v=%0d: got %0d busy cycles expected 15", vals[n], bcnt); end
      tests++;
      if ({Hexs, LES} !== exp) begin fails++; $display("FAIL conv_out v=%0d: got %h/%b expected %h/%b", vals[n], Hexs, LES, exp[19:4], exp[3:0]); end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL conv_done_pulse v=%0d: got done=%b busy=%b expected 0 0", vals[n], done, busy); end
    end
  endtask

  task automatic test_saturate;
    int vals[3] = '{12000, 16383, 10000};
    for (int n = 0; n < 3; n++) begin
      int cyc;
      bit seen;
      logic [19:0] exp;
      cyc = 0; seen = 0;
      sb_q.push_back({model_bcd(vals[n]), model_les(model_bcd(vals[n]))});
      drive_load(vals[n]);
      while (!seen && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (done === 1'b1) seen = 1;
      end
      exp = sb_q.pop_front();
      tests++;
      if (!seen || {Hexs, LES} !== exp) begin
        fails++;
        $display("FAIL saturate v=%0d: got seen=%0d %h/%b expected %h/%b", vals[n], seen, Hexs, LES, exp[19:4], exp[3:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, ndone, c1, c2;
    bit gap, saw300;
    logic [19:0] exp;
    ndone = 0; gap = 0; saw300 = 0; c1 = 0; c2 = 0;
    sb_q.push_back({model_bcd(42), model_les(model_bcd(42))});
    sb_q.push_back({model_bcd(512), model_les(model_bcd(512))});
    drive_load(42);
    repeat (4) @(posedge clk);
    #1 load = 1'b1; value = 14'd300;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (2) @(posedge clk);
    #1 load = 1'b1; value = 14'd512;
    @(posedge clk);
    #1 load = 1'b0;
    cyc = 8;
    while (ndone < 2 && cyc < 70) begin
      @(negedge clk);
      cyc++;
      if (Hexs === 16'h0300) saw300 = 1;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) c1 = cyc; else c2 = cyc;
        exp = sb_q.pop_front();
        tests++;
        if ({Hexs, LES} !== exp) begin fails++; $display("FAIL chain_out%0d: got %h/%b expected %h/%b", ndone, Hexs, LES, exp[19:4], exp[3:0]); end
      end
      if (ndone < 2 && busy !== 1'b1) gap = 1;
    end
    tests++;
    if (ndone != 2 || c1 != 16 || c2 != 31) begin fails++; $display("FAIL chain_done: got %0d pulses at %0d,%0d expected 2 at 16,31", ndone, c1, c2); end
    tests++;
    if (gap || saw300) begin fails++; $display("FAIL chain_busy: got gap=%0d saw300=%0d expected 0 0", gap, saw300); end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL chain_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    ndone = 0;
    drive_load(8888);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    // Negedge here follows the reset edge plus half a cycle; outputs must be at reset values.
    tests++;
    if (Hexs !== 16'h0000 || LES !== 4'b1110 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL midreset_vals: got %h/%b busy=%b done=%b expected 0000/1110 0 0", Hexs, LES, busy, done);
    end
    tests++;
    if (Scan !== 2'd0) begin fails++; $display("FAIL midreset_scan: got %0d expected 0", Scan); end
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    tests++;
    if (ndone != 0 || busy !== 1'b0) begin fails++; $display("FAIL midreset_nodone: got %0d pulses busy=%b expected 0 0", ndone, busy); end
    tests++;
    if (sb_q.size() != 0) begin fails++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0;
    test_reset();
    test_values();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
